// File: rtl/aes_loader_pkg.sv
// Shared constants and types for the AES block loader.
package aes_loader_pkg;

    localparam int unsigned BLK_BYTES = 16;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned BLK_W     = BLK_BYTES * BYTE_W;

    typedef enum logic {FILL, PRESENT} loader_state_t;

endpackage

// File: rtl/aes_block_loader_if.sv
// FIFO read side, flush request and block handshake seen by the loader.
interface aes_block_loader_if;
    import aes_loader_pkg::*;

    logic              fifo_empty;
    logic [BYTE_W-1:0] fifo_r_data;
    logic              fifo_r_enable;
    logic              flush;
    logic [BLK_W-1:0]  blk_data;
    logic [CNT_W-1:0]  blk_len;
    logic              blk_last;
    logic              blk_valid;
    logic              blk_ready;

    // Loader side.
    modport master (
        input  fifo_empty,
        input  fifo_r_data,
        output fifo_r_enable,
        input  flush,
        output blk_data,
        output blk_len,
        output blk_last,
        output blk_valid,
        input  blk_ready
    );

    // FIFO and AES core side.
    modport slave (
        output fifo_empty,
        output fifo_r_data,
        input  fifo_r_enable,
        output flush,
        input  blk_data,
        input  blk_len,
        input  blk_last,
        input  blk_valid,
        output blk_ready
    );

endinterface

// File: rtl/flex_counter.sv
// Up counter with synchronous clear (priority) and count enable.
module flex_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    output logic [Width-1:0] count_out
);

    logic [Width-1:0] count_q;

    // Count register: clear wins over enable.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count_enable) begin
            count_q <= count_q + Width'(1);
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/aes_block_loader.sv
// Packs FIFO bytes into 128-bit AES blocks; flush closes a zero-padded partial block.
module aes_block_loader
    import aes_loader_pkg::*;
(
    input logic                clk,
    input logic                n_rst,
    aes_block_loader_if.master bus
);

    loader_state_t    state_q;
    logic [CNT_W-1:0] cnt;
    logic [BLK_W-1:0] asm_q;
    logic [BLK_W-1:0] asm_d;
    logic             flush_pend_q;
    logic [CNT_W-1:0] blk_len_q;
    logic             blk_last_q;
    logic             blk_valid_q;

    logic pop;
    logic handshake;
    logic last_pop;
    logic flush_now;

    // FIFO is first-word fall-through, so popping is purely a function of state and empty.
    assign pop       = (state_q == FILL) && !bus.fifo_empty;
    assign handshake = blk_valid_q && bus.blk_ready;
    assign last_pop  = pop && (cnt == CNT_W'(BLK_BYTES - 1));
    // Only reachable with the FIFO drained, so it never coincides with a pop.
    assign flush_now = (state_q == FILL) && bus.fifo_empty && flush_pend_q;

    flex_counter #(
        .Width (CNT_W)
    ) u_lane_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (handshake),
        .count_enable (pop),
        .count_out    (cnt)
    );

    // Lane write: byte n of the block lands at [127-8n -: 8]; handshake zeroes all lanes.
    always_comb begin
        asm_d = asm_q;
        if (handshake) begin
            asm_d = '0;
        end else if (pop) begin
            for (int unsigned i = 0; i < BLK_BYTES; i++) begin
                if (cnt == CNT_W'(i)) begin
                    asm_d[BLK_W - 1 - BYTE_W * i -: BYTE_W] = bus.fifo_r_data;
                end
            end
        end
    end

    // Assembly register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            asm_q <= '0;
        end else begin
            asm_q <= asm_d;
        end
    end

    // Control FSM with flush latch and registered block qualifiers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= FILL;
            flush_pend_q <= 1'b0;
            blk_len_q    <= '0;
            blk_last_q   <= 1'b0;
            blk_valid_q  <= 1'b0;
        end else begin
            // A new request is never lost, even when it meets a consumed one.
            if (bus.flush) begin
                flush_pend_q <= 1'b1;
            end else if (flush_now) begin
                flush_pend_q <= 1'b0;
            end

            case (state_q)
                FILL: begin
                    if (last_pop) begin
                        state_q     <= PRESENT;
                        blk_valid_q <= 1'b1;
                        blk_len_q   <= CNT_W'(BLK_BYTES);
                        blk_last_q  <= 1'b0;
                    end else if (flush_now && (cnt != '0)) begin
                        state_q     <= PRESENT;
                        blk_valid_q <= 1'b1;
                        blk_len_q   <= cnt;
                        blk_last_q  <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (handshake) begin
                        state_q     <= FILL;
                        blk_valid_q <= 1'b0;
                        blk_len_q   <= '0;
                        blk_last_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.fifo_r_enable = pop;
    assign bus.blk_data      = asm_q;
    assign bus.blk_len       = blk_len_q;
    assign bus.blk_last      = blk_last_q;
    assign bus.blk_valid     = blk_valid_q;

endmodule
